// File: rtl/body_update_scheduler.sv
`timescale 1ns/1ps
// Per-frame three-body physics sequencer that shares one force unit across the three body pairs.
// Tick to publish takes 6 cycles when the force unit acks in the same cycle; each unacked pair times out after TIMEOUT cycles.
module body_update_scheduler #(
    parameter int POS_W   = 10,
    parameter int VEL_W   = 10,
    parameter int ACC_W   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    frame_tick,
    input  logic                    run,
    output logic                    fu_req,
    output logic [1:0]              fu_sel_a,
    output logic [1:0]              fu_sel_b,
    output logic [POS_W-1:0]        fu_ax,
    output logic [POS_W-1:0]        fu_ay,
    output logic [POS_W-1:0]        fu_bx,
    output logic [POS_W-1:0]        fu_by,
    input  logic                    fu_ack,
    input  logic signed [ACC_W-1:0] fu_fx,
    input  logic signed [ACC_W-1:0] fu_fy,
    output logic [3*POS_W-1:0]      pos_x,
    output logic [3*POS_W-1:0]      pos_y,
    output logic                    busy,
    output logic                    update_done,
    output logic                    overrun,
    output logic                    fault
);

    localparam int AW = ACC_W + 2;
    localparam int SW = (POS_W > VEL_W) ? POS_W : VEL_W;
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PAIR  = 2'd1;
    localparam logic [1:0] S_INTEG = 2'd2;
    localparam logic [1:0] S_PUB   = 2'd3;

    localparam logic signed [VEL_W:0] VMAX = (VEL_W+1)'((1 << (VEL_W-1)) - 1);
    localparam logic signed [VEL_W:0] VMIN = -VMAX;

    localparam logic [3*POS_W-1:0] INIT_X = {POS_W'(200), POS_W'(420), POS_W'(300)};
    localparam logic [3*POS_W-1:0] INIT_Y = {POS_W'(20),  POS_W'(300), POS_W'(150)};

    logic [1:0]              state;
    logic [1:0]              k;
    logic [CW-1:0]           cnt;
    logic [POS_W-1:0]        px [3];
    logic [POS_W-1:0]        py [3];
    logic signed [VEL_W-1:0] vx [3];
    logic signed [VEL_W-1:0] vy [3];
    logic signed [AW-1:0]    ax [3];
    logic signed [AW-1:0]    ay [3];
    logic signed [AW-1:0]    fx_e;
    logic signed [AW-1:0]    fy_e;
    logic                    pair_end;

    function automatic logic [POS_W-1:0] vstep(input logic signed [VEL_W-1:0] v);
        logic signed [SW-1:0] w;
        w = SW'(v);
        return w[POS_W-1:0];
    endfunction

    function automatic logic signed [VEL_W-1:0] sat_add(input logic signed [VEL_W-1:0] v,
                                                        input logic signed [AW-1:0] a);
        logic signed [VEL_W:0] s;
        s = (VEL_W+1)'(v) + (VEL_W+1)'(a);
        if (s > VMAX)
            s = VMAX;
        else if (s < VMIN)
            s = VMIN;
        return s[VEL_W-1:0];
    endfunction

    assign fx_e     = {{2{fu_fx[ACC_W-1]}}, fu_fx};
    assign fy_e     = {{2{fu_fy[ACC_W-1]}}, fu_fy};
    assign fu_req   = (state == S_PAIR);
    assign busy     = (state != S_IDLE);
    assign pair_end = fu_ack || (cnt == CW'(TIMEOUT - 1));

    // Operands depend only on k and the working positions, both frozen during a pair.
    always_comb begin
        fu_sel_a = 2'd0;
        fu_sel_b = 2'd1;
        case (k)
            2'd0: fu_sel_b = 2'd1;
            2'd1: fu_sel_b = 2'd2;
            default: begin
                fu_sel_a = 2'd1;
                fu_sel_b = 2'd2;
            end
        endcase
        fu_ax = (fu_sel_a == 2'd0) ? px[0] : px[1];
        fu_ay = (fu_sel_a == 2'd0) ? py[0] : py[1];
        fu_bx = (fu_sel_b == 2'd1) ? px[1] : px[2];
        fu_by = (fu_sel_b == 2'd1) ? py[1] : py[2];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            k           <= 2'd0;
            cnt         <= '0;
            pos_x       <= INIT_X;
            pos_y       <= INIT_Y;
            update_done <= 1'b0;
            overrun     <= 1'b0;
            fault       <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                px[i] <= INIT_X[i*POS_W +: POS_W];
                py[i] <= INIT_Y[i*POS_W +: POS_W];
                vx[i] <= '0;
                vy[i] <= '0;
                ax[i] <= '0;
                ay[i] <= '0;
            end
        end else begin
            update_done <= 1'b0;
            if (frame_tick && state != S_IDLE)
                overrun <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (frame_tick && run) begin
                        state <= S_PAIR;
                        k     <= 2'd0;
                        cnt   <= '0;
                        for (int i = 0; i < 3; i++) begin
                            ax[i] <= '0;
                            ay[i] <= '0;
                        end
                    end
                end
                S_PAIR: begin
                    if (pair_end) begin
                        if (fu_ack) begin
                            // Equal and opposite: A gets +f, B gets -f.
                            for (int i = 0; i < 3; i++) begin
                                if (2'(i) == fu_sel_a) begin
                                    ax[i] <= ax[i] + fx_e;
                                    ay[i] <= ay[i] + fy_e;
                                end else if (2'(i) == fu_sel_b) begin
                                    ax[i] <= ax[i] - fx_e;
                                    ay[i] <= ay[i] - fy_e;
                                end
                            end
                        end else begin
                            fault <= 1'b1;
                        end
                        cnt <= '0;
                        if (k == 2'd2)
                            state <= S_INTEG;
                        else
                            k <= k + 2'd1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_INTEG: begin
                    // Position advances by the old velocity; velocity picks up this frame's acceleration.
                    for (int i = 0; i < 3; i++) begin
                        px[i] <= px[i] + vstep(vx[i]);
                        py[i] <= py[i] + vstep(vy[i]);
                        vx[i] <= sat_add(vx[i], ax[i]);
                        vy[i] <= sat_add(vy[i], ay[i]);
                    end
                    state <= S_PUB;
                end
                default: begin
                    for (int i = 0; i < 3; i++) begin
                        pos_x[i*POS_W +: POS_W] <= px[i];
                        pos_y[i*POS_W +: POS_W] <= py[i];
                    end
                    update_done <= 1'b1;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_body_update_scheduler.sv
`timescale 1ns/1ps
// Directed bench for body_update_scheduler: reset values, pair sequencing, ack latency, timeouts, overrun, saturation and wrap.
module tb_body_update_scheduler;

    logic              clk = 1'b0;
    logic              reset;
    logic              frame_tick;
    logic              run;
    logic              fu_req;
    logic [1:0]        fu_sel_a;
    logic [1:0]        fu_sel_b;
    logic [9:0]        fu_ax, fu_ay, fu_bx, fu_by;
    logic              fu_ack;
    logic signed [3:0] fu_fx, fu_fy;
    logic [29:0]       pos_x, pos_y;
    logic              busy, update_done, overrun, fault;

    int checks = 0;
    int errors = 0;

    body_update_scheduler #(.POS_W(10), .VEL_W(10), .ACC_W(4), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .run(run),
        .fu_req(fu_req), .fu_sel_a(fu_sel_a), .fu_sel_b(fu_sel_b),
        .fu_ax(fu_ax), .fu_ay(fu_ay), .fu_bx(fu_bx), .fu_by(fu_by),
        .fu_ack(fu_ack), .fu_fx(fu_fx), .fu_fy(fu_fy),
        .pos_x(pos_x), .pos_y(pos_y), .busy(busy), .update_done(update_done),
        .overrun(overrun), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] bx(input int i);
        return pos_x[i*10 +: 10];
    endfunction

    function automatic logic [9:0] by(input int i);
        return pos_y[i*10 +: 10];
    endfunction

    task automatic do_reset();
        reset      = 1'b1;
        frame_tick = 1'b0;
        fu_ack     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Caller has raised frame_tick at a negedge; returns the cycle offset of update_done.
    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            frame_tick = 1'b0;
            cyc++;
        end while (!update_done && cyc < 200);
    endtask

    task automatic chk_init_pos(input string tag);
        chk({tag, "_pos_x"}, {34'd0, pos_x}, {34'd0, 10'd200, 10'd420, 10'd300});
        chk({tag, "_pos_y"}, {34'd0, pos_y}, {34'd0, 10'd20, 10'd300, 10'd150});
    endtask

    int ea [3] = '{0, 0, 1};
    int eb [3] = '{1, 2, 2};
    int ix [3] = '{300, 420, 200};
    int iy [3] = '{150, 300, 20};

    initial begin
        int cyc;
        int pulses;
        logic [1:0] sb16, sb17;

        run   = 1'b0;
        fu_fx = 4'sd0;
        fu_fy = 4'sd0;
        @(negedge clk);
        do_reset();

        // 1: reset state
        chk_init_pos("rst");
        chk("rst_busy", busy, 0);
        chk("rst_req", fu_req, 0);
        chk("rst_flags", {update_done, overrun, fault}, 0);

        // paused tick is ignored without a flag
        frame_tick = 1'b1;
        run        = 1'b0;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        chk("pause_busy", busy, 0);
        chk("pause_overrun", overrun, 0);

        // 2: zero-wait ack, fx=1
        fu_ack     = 1'b1;
        fu_fx      = 4'sd1;
        fu_fy      = 4'sd0;
        run        = 1'b1;
        frame_tick = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            frame_tick = 1'b0;
            if (c <= 3) begin
                chk($sformatf("t2_sel_c%0d", c), {fu_req, fu_sel_a, fu_sel_b},
                    {1'b1, 2'(ea[c-1]), 2'(eb[c-1])});
                chk($sformatf("t2_busy_c%0d", c), busy, 1);
            end else if (c <= 5) begin
                chk($sformatf("t2_int_c%0d", c), {busy, fu_req, update_done}, 3'b100);
            end else begin
                chk("t2_done", {busy, update_done}, 2'b01);
                chk_init_pos("t2_frame1");
            end
        end
        frame_tick = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            frame_tick = 1'b0;
            if (c == 5)
                chk("t2_no_tear", bx(0), 300);
        end
        chk("t2_x0", bx(0), 302);
        chk("t2_x1", bx(1), 420);
        chk("t2_x2", bx(2), 198);
        chk("t2_y", {34'd0, pos_y}, {34'd0, 10'd20, 10'd300, 10'd150});
        chk("t2_flags", {overrun, fault}, 0);

        // 3: ack five cycles after each request; operands held stable
        do_reset();
        fu_fx      = 4'sd2;
        fu_fy      = -4'sd1;
        frame_tick = 1'b1;
        for (int p = 0; p < 3; p++) begin
            for (int j = 0; j <= 5; j++) begin
                @(negedge clk);
                frame_tick = 1'b0;
                fu_ack     = (j == 5);
                chk($sformatf("t3_ops_p%0d_j%0d", p, j),
                    {fu_req, fu_sel_a, fu_sel_b, fu_ax, fu_ay, fu_bx, fu_by},
                    {1'b1, 2'(ea[p]), 2'(eb[p]), 10'(ix[ea[p]]), 10'(iy[ea[p]]),
                     10'(ix[eb[p]]), 10'(iy[eb[p]])});
            end
        end
        @(negedge clk);
        fu_ack = 1'b0;
        chk("t3_c19", {busy, fu_req, update_done}, 3'b100);
        @(negedge clk);
        chk("t3_c20", {busy, update_done}, 2'b10);
        @(negedge clk);
        chk("t3_c21_done", {busy, update_done}, 2'b01);
        chk_init_pos("t3");
        chk("t3_fault", fault, 0);

        // 4: no ack, every pair times out
        do_reset();
        fu_ack     = 1'b0;
        frame_tick = 1'b1;
        cyc  = 0;
        sb16 = 2'd0;
        sb17 = 2'd0;
        do begin
            @(negedge clk);
            frame_tick = 1'b0;
            cyc++;
            if (cyc == 16) sb16 = fu_sel_b;
            if (cyc == 17) sb17 = fu_sel_b;
        end while (!update_done && cyc < 200);
        chk("t4_done_cycle", cyc, 51);
        chk("t4_pair_switch", {sb16, sb17}, {2'd1, 2'd2});
        chk("t4_fault", fault, 1);
        chk_init_pos("t4");

        // reset in the middle of an update drops fu_req on the next cycle
        do_reset();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        chk("mid_req_before", fu_req, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_req_after", {fu_req, busy}, 2'b00);
        reset = 1'b0;

        // 5: tick at T+3 flags overrun, single update_done
        do_reset();
        fu_ack     = 1'b1;
        fu_fx      = 4'sd1;
        fu_fy      = 4'sd0;
        frame_tick = 1'b1;
        pulses     = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            frame_tick = (c == 3);
            if (update_done) pulses++;
        end
        chk("t5_pulses", pulses, 1);
        chk("t5_overrun", overrun, 1);
        chk("t5_busy", busy, 0);

        // 6: fx=7 every pair for 40 frames: v0 clamps at 511, x0 wraps
        do_reset();
        fu_ack = 1'b1;
        fu_fx  = 4'sd7;
        fu_fy  = 4'sd0;
        for (int f = 0; f < 40; f++) begin
            frame_tick = 1'b1;
            wait_done(cyc);
            if (f == 0)
                chk("t6_latency", cyc, 6);
        end
        chk("t6_x0_f40", bx(0), 917);
        chk("t6_x1_f40", bx(1), 420);
        chk("t6_x2_f40", bx(2), 607);
        chk("t6_y_f40", {by(0), by(1), by(2)}, {10'd150, 10'd300, 10'd20});
        frame_tick = 1'b1;
        wait_done(cyc);
        chk("t6_x0_f41", bx(0), 404);
        chk("t6_x2_f41", bx(2), 96);
        chk("t6_flags", {overrun, fault}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
